song_recorder: RTL and testbench

- Record-mode counterpart to the play/score path: the play path reads notes from a song table and scores the player's hits; this block writes the player's hits into a note table.
- Each accepted hit stores octave, note, length and the tick-gap since the previous note.
- A registered read port with song-table-style indexing lets the play and sound logic replay the recording.
- Sits beside the play-mode top and is enabled by the mode selector.

---
 rtl/song_recorder_pkg.sv | 42 ++++
 rtl/song_recorder_key.sv | 24 ++
 rtl/song_recorder.sv | 150 +++++++++++++++
 tb/tb_song_recorder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/song_recorder_pkg.sv
// Shared widths, state type and entry layout for the song recorder.
package song_recorder_pkg;

  localparam int OCT_W     = 2;
  localparam int OCT_MAX   = 3;
  localparam int OCT_RESET = 1;
  localparam int NOTE_W    = 3;
  localparam int LEN_W     = 3;
  localparam int GAP_W     = 12;
  localparam int DEPTH     = 64;
  localparam int CNT_W     = 7;
  localparam int ADDR_W    = $clog2(DEPTH);

  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_REC,
    ST_DONE
  } rec_state_t;

  // Stored entry, MSB first: {octave, note, length, gap}
  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  length;
    logic [GAP_W-1:0]  gap;
  } entry_t;

  // Saturating octave move; simultaneous up and down cancel out.
  function automatic logic [OCT_W-1:0] octave_step(input logic [OCT_W-1:0] oct,
                                                   input logic up,
                                                   input logic down);
    octave_step = oct;
    if (up && !down && oct != OCT_W'(OCT_MAX))
      octave_step = oct + 1'b1;
    else if (down && !up && oct != '0)
      octave_step = oct - 1'b1;
  endfunction

endpackage

// File: rtl/song_recorder_key.sv
// Registered rising-edge detector for a level key; pulse lags the key edge by one cycle.
module key_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic rise
);

  logic prev_reg;
  logic rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      prev_reg <= key;
      rise_reg <= key && !prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/song_recorder.sv
// Record-mode note table: captures hits with octave, note, length and tick gap,
// and exposes a registered read port for replay.
module song_recorder
  import song_recorder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tick,
  input  logic              hit,
  input  logic              stop,
  input  logic              oct_up,
  input  logic              oct_down,
  input  logic [NOTE_W-1:0] note_key,
  input  logic [LEN_W-1:0]  length_key,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [OCT_W-1:0]  rd_octave,
  output logic [NOTE_W-1:0] rd_note,
  output logic [LEN_W-1:0]  rd_length,
  output logic [GAP_W-1:0]  rd_gap,
  output logic [CNT_W-1:0]  track,
  output logic [OCT_W-1:0]  octave,
  output logic              recording,
  output logic              full,
  output logic              overflow
);

  logic [3:0] key_vec;
  logic [3:0] rise_vec;
  logic       hit_pulse, stop_pulse, up_pulse, down_pulse;

  assign key_vec = {hit, stop, oct_up, oct_down};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_rise u_key_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_vec[gi]),
        .rise  (rise_vec[gi])
      );
    end
  endgenerate

  assign {hit_pulse, stop_pulse, up_pulse, down_pulse} = rise_vec;

  rec_state_t       state_reg;
  logic [CNT_W-1:0] track_reg;
  logic [OCT_W-1:0] octave_reg;
  logic [GAP_W-1:0] gap_reg;
  logic             recording_reg;
  logic             full_reg;
  logic             overflow_reg;
  logic             en_prev_reg;

  logic   active;
  logic   hit_ok;
  logic   wr_en;
  entry_t wr_entry;
  entry_t rd_entry_reg;
  entry_t mem [DEPTH];

  assign active   = en && (state_reg == ST_ARMED || state_reg == ST_REC);
  assign hit_ok   = active && hit_pulse && (note_key != '0);
  assign wr_en    = hit_ok && !full_reg;
  // Hit uses the octave before any same-cycle octave key takes effect.
  assign wr_entry = {octave_reg, note_key, length_key, gap_reg};

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[track_reg[ADDR_W-1:0]] <= wr_entry;
  end

  // Read-before-write; entries beyond the current take read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_entry_reg <= '0;
    else if (rd_idx < track_reg)
      rd_entry_reg <= mem[rd_idx[ADDR_W-1:0]];
    else
      rd_entry_reg <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      track_reg     <= '0;
      octave_reg    <= OCT_W'(OCT_RESET);
      gap_reg       <= '0;
      recording_reg <= 1'b0;
      full_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      en_prev_reg   <= 1'b0;
    end else begin
      en_prev_reg <= en;
      if (!en) begin
        state_reg     <= ST_IDLE;
        recording_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (!en_prev_reg) begin
              state_reg     <= ST_ARMED;
              track_reg     <= '0;
              octave_reg    <= OCT_W'(OCT_RESET);
              gap_reg       <= '0;
              full_reg      <= 1'b0;
              overflow_reg  <= 1'b0;
              recording_reg <= 1'b1;
            end
          end
          ST_ARMED, ST_REC: begin
            octave_reg <= octave_step(octave_reg, up_pulse, down_pulse);
            if (wr_en) begin
              track_reg <= track_reg + 1'b1;
              full_reg  <= (track_reg == CNT_W'(DEPTH - 1));
            end else if (hit_ok) begin
              overflow_reg <= 1'b1;
            end
            if (state_reg == ST_REC) begin
              if (wr_en)
                gap_reg <= '0;
              else if (tick && gap_reg != GAP_MAX)
                gap_reg <= gap_reg + 1'b1;
            end
            if (stop_pulse) begin
              state_reg     <= ST_DONE;
              recording_reg <= 1'b0;
            end else if (state_reg == ST_ARMED && hit_ok) begin
              state_reg <= ST_REC;
            end
          end
          ST_DONE: state_reg <= ST_DONE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_octave = rd_entry_reg.octave;
  assign rd_note   = rd_entry_reg.note;
  assign rd_length = rd_entry_reg.length;
  assign rd_gap    = rd_entry_reg.gap;
  assign track     = track_reg;
  assign octave    = octave_reg;
  assign recording = recording_reg;
  assign full      = full_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_song_recorder.sv
// Directed and randomized bench for song_recorder against a queue-based model of the take.
module tb_song_recorder;
  import song_recorder_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              tick = 1'b0;
  logic              hit = 1'b0;
  logic              stop = 1'b0;
  logic              oct_up = 1'b0;
  logic              oct_down = 1'b0;
  logic [NOTE_W-1:0] note_key = '0;
  logic [LEN_W-1:0]  length_key = '0;
  logic [CNT_W-1:0]  rd_idx = '0;
  logic [OCT_W-1:0]  rd_octave;
  logic [NOTE_W-1:0] rd_note;
  logic [LEN_W-1:0]  rd_length;
  logic [GAP_W-1:0]  rd_gap;
  logic [CNT_W-1:0]  track;
  logic [OCT_W-1:0]  octave;
  logic              recording;
  logic              full;
  logic              overflow;

  song_recorder dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .hit(hit), .stop(stop),
    .oct_up(oct_up), .oct_down(oct_down), .note_key(note_key), .length_key(length_key),
    .rd_idx(rd_idx), .rd_octave(rd_octave), .rd_note(rd_note), .rd_length(rd_length),
    .rd_gap(rd_gap), .track(track), .octave(octave), .recording(recording),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the take is a list of notes; mode is a few flags.
  int m_oct_q[$];
  int m_note_q[$];
  int m_len_q[$];
  int m_gap_q[$];
  int m_octave = 1;
  int m_gap = 0;
  bit m_en = 0, m_armed = 0, m_rec = 0, m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".track"}, 32'(track), 32'(m_note_q.size()));
    chk({tag, ".octave"}, 32'(octave), 32'(m_octave));
    chk({tag, ".recording"}, 32'(recording), 32'(m_en && (m_armed || m_rec)));
    chk({tag, ".full"}, 32'(full), 32'(m_note_q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic check_rd_zero(input string tag);
    chk({tag, ".rd_octave"}, 32'(rd_octave), 0);
    chk({tag, ".rd_note"}, 32'(rd_note), 0);
    chk({tag, ".rd_length"}, 32'(rd_length), 0);
    chk({tag, ".rd_gap"}, 32'(rd_gap), 0);
  endtask

  task automatic check_read(input int idx, input string tag);
    rd_idx = CNT_W'(idx);
    step();
    if (idx < m_note_q.size()) begin
      chk({tag, ".rd_octave"}, 32'(rd_octave), 32'(m_oct_q[idx]));
      chk({tag, ".rd_note"}, 32'(rd_note), 32'(m_note_q[idx]));
      chk({tag, ".rd_length"}, 32'(rd_length), 32'(m_len_q[idx]));
      chk({tag, ".rd_gap"}, 32'(rd_gap), 32'(m_gap_q[idx]));
    end else begin
      check_rd_zero(tag);
    end
  endtask

  task automatic set_en(input bit v);
    en = v;
    step();
    if (v && !m_en) begin
      m_oct_q.delete(); m_note_q.delete(); m_len_q.delete(); m_gap_q.delete();
      m_ovf = 0; m_octave = 1; m_gap = 0; m_armed = 1; m_rec = 0;
    end else if (!v) begin
      m_armed = 0; m_rec = 0;
    end
    m_en = v;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0;
    if (m_en && m_rec) m_gap = (m_gap + n > 4095) ? 4095 : m_gap + n;
  endtask

  // Key held for one edge; the detector pulse acts on the following edge.
  task automatic press(input bit h, input bit s, input bit u, input bit d,
                       input int nt, input int ln);
    note_key = NOTE_W'(nt); length_key = LEN_W'(ln);
    hit = h; stop = s; oct_up = u; oct_down = d;
    step();
    hit = 0; stop = 0; oct_up = 0; oct_down = 0;
    step();
    if (m_en && (m_armed || m_rec)) begin
      if (h && nt != 0) begin
        if (m_note_q.size() < DEPTH) begin
          m_oct_q.push_back(m_octave);
          m_note_q.push_back(nt);
          m_len_q.push_back(ln);
          m_gap_q.push_back(m_armed ? 0 : m_gap);
          m_gap = 0;
        end else begin
          m_ovf = 1;
        end
        if (m_armed) begin m_armed = 0; m_rec = 1; end
      end
      if (u && !d && m_octave < 3) m_octave++;
      else if (d && !u && m_octave > 0) m_octave--;
      if (s) begin m_armed = 0; m_rec = 0; end
    end
  endtask

  task automatic apply_reset_model();
    m_oct_q.delete(); m_note_q.delete(); m_len_q.delete(); m_gap_q.delete();
    m_octave = 1; m_gap = 0; m_en = 0; m_armed = 0; m_rec = 0; m_ovf = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state
    repeat (3) step();
    check_status("reset");
    check_rd_zero("reset");
    rst_n = 1'b1;
    step();
    check_read(0, "reset_rd");

    // First note in ARMED
    set_en(1);
    check_status("armed");
    press(1, 0, 0, 0, 3, 2);
    check_status("first_hit");
    check_read(0, "entry0");

    // Gap counting and saturation
    ticks(5);
    press(1, 0, 0, 0, 5, 1);
    check_status("gap5");
    check_read(1, "entry1");
    ticks(5000);
    press(1, 0, 0, 0, 7, 4);
    check_read(2, "gap_sat");

    // Octave saturation, cancel, and hit with octave-down
    repeat (4) press(0, 0, 1, 0, 0, 0);
    check_status("oct_sat");
    press(0, 0, 1, 1, 0, 0);
    check_status("oct_both");
    ticks(2);
    press(1, 0, 0, 1, 6, 3);
    check_status("hit_down");
    check_read(3, "entry3");

    // note 0 ignored
    press(1, 0, 0, 0, 0, 5);
    check_status("note0");

    // Randomized fill to the end of the table
    while (m_note_q.size() < DEPTH) begin
      ticks($urandom_range(0, 20));
      press(1, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        t = $urandom_range(0, m_note_q.size() + 2);
        check_read(t, "rand_rd");
      end
    end
    check_status("full");
    press(1, 0, 0, 0, 4, 4);
    check_status("overflow");
    check_read(63, "entry63");

    // Replay after en drop, then new take
    set_en(0);
    check_status("en_off");
    check_read(m_note_q.size() - 1, "replay_last");
    check_read(m_note_q.size(), "replay_past");
    set_en(1);
    check_status("new_take");
    press(1, 0, 0, 0, 2, 6);
    ticks($urandom_range(1, 30));
    press(1, 1, 0, 0, 1, 7);
    check_status("hit_stop");
    check_read(1, "hit_stop_rd");
    press(1, 0, 0, 0, 5, 5);
    check_status("done_ignore");

    // Async reset mid-recording
    set_en(0);
    set_en(1);
    press(1, 0, 1, 0, 3, 3);
    ticks(4);
    press(1, 0, 0, 0, 6, 1);
    rd_idx = '0;
    step();
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    apply_reset_model();
    check_status("async_rst");
    check_rd_zero("async_rst");
    step();
    rst_n = 1'b1;
    step();
    check_status("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
